spi_peripheral: RTL
===================

# spi_peripheral

Parametrised SPI target port: generalises the fixed mode-3, 8-bit receiver to any word width and any of the four SPI modes. Full duplex, with a valid/ready receive stream, a valid/ready transmit stream, and sticky overrun/underrun/abort status. Sits between the external SPI pins and the internal byte/word fabric. All SPI inputs are oversampled by the system clock.

## Interface
Parameters:
- DATA_WIDTH, 8: bits per SPI word, 2..32.
- CPOL, 1: idle level of SPI_clock.
- CPHA, 1: 0 = sample on the leading edge, 1 = sample on the trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first, 0 = LSB first.
- SYNC_STAGES, 2: synchroniser flops per SPI input, ≥2.

Ports:
- clock  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- SPI_clock  in  1  serial clock from the controller.
- SPI_in  in  1  controller-to-target data (MOSI).
- SPI_out  out  1  target-to-controller data (MISO).
- SPI_out_enable  out  1  1 while selected; pad tristate control.
- SPI_not_chip_select  in  1  active-low select.
- in_data_valid  out  1  received word available.
- in_data  out  DATA_WIDTH  received word; stable while valid.
- in_data_ready  in  1  consumer accepts in_data.
- out_data_valid  in  1  word to transmit available.
- out_data  in  DATA_WIDTH  word to transmit.
- out_data_ready  out  1  one-cycle pulse: out_data taken.
- status_clear  in  1  clears the sticky flags.
- overrun  out  1  sticky: a received word was dropped.
- underrun  out  1  sticky: a word was sent with no out_data available.
- aborted  out  1  sticky: select was deasserted mid-word.
- busy  out  1  state is ACTIVE.

## Operation
- Input conditioning:
  - SPI_clock, SPI_in and SPI_not_chip_select each pass through SYNC_STAGES flops, then a 1-flop edge detector.
  - Leading edge = falling if CPOL else rising. Trailing edge = the opposite edge.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- States: IDLE and ACTIVE.
  - IDLE -> ACTIVE on the synchronised select falling edge.
  - ACTIVE -> IDLE on the synchronised select rising edge.
- Select falling edge:
  - bit_count <= 0.
  - tx shift register is loaded (see Load).
- Sample edge in ACTIVE:
  - Synchronised SPI_in enters the rx shift register at the MSB_FIRST-selected end.
  - bit_count increments.
  - When bit_count == DATA_WIDTH-1, the word completes and bit_count wraps to 0.
- Word complete:
  - If in_data_valid=0, or in_data_ready=1 in the same cycle: in_data <= rx word and in_data_valid <= 1.
  - Otherwise the new word is dropped, in_data holds its old value, and overrun <= 1.
  - The tx shift register reloads (Load).
- Load:
  - If out_data_valid: tx <= out_data and out_data_ready pulses for 1 cycle.
  - Else: tx <= all ones and underrun <= 1.
  - If CPHA=1, the next shift edge after a load does not shift; the first bit is already presented.
- Shift edge in ACTIVE: tx shifts by one toward the output end.
- SPI_out = tx MSB when MSB_FIRST=1, tx LSB when MSB_FIRST=0. SPI_out = 1 in IDLE.
- in_data_valid clears on a cycle with valid & ready and no new word completing.
- Select rising edge with bit_count ≠ 0:
  - Partial word discarded, aborted <= 1, bit_count <= 0.
- status_clear zeroes overrun, underrun and aborted. A flag set event in the same cycle wins.
- Reset forces all state and outputs to reset values in the same clock edge, including mid-word; partial words are lost without setting aborted.

## Timing
- Reset values:
  - in_data_valid, in_data, out_data_ready, overrun, underrun, aborted, busy, SPI_out_enable: all 0.
  - SPI_out: 1.
  - State IDLE, bit_count 0.
- Pin-to-event latency: SYNC_STAGES+1 clocks from any pin transition to its internal edge pulse.
- in_data_valid rises 1 clock after the final sample-edge pulse: SYNC_STAGES+2 clocks after the pin edge.
- out_data_ready pulses in the clock after the select-falling or word-complete pulse.
- SPI_out changes SYNC_STAGES+2 clocks after the shift-edge pin transition. The controller's SPI_clock half-period must be ≥ SYNC_STAGES+3 clocks.
- Simultaneous final sample edge and select rising edge: the word completes first, then the block goes IDLE. aborted is not set.
- SPI_out_enable follows busy, registered.

## Configuration
- SPI_PERIPHERAL_TX_EN defined: transmit path, out_data_ready and underrun function as described.
- SPI_PERIPHERAL_TX_EN undefined:
  - No tx register.
  - SPI_out constant 1, SPI_out_enable constant 0.
  - out_data_ready and underrun constant 0.
  - out_data and out_data_valid are ignored.
  - Receive behaviour is unchanged.

## Test plan
- Mode 3, width 8: controller sends 0xA5 and out_data = 0x3C is preloaded -> in_data = 0xA5 with one valid pulse; MISO carries 0x3C MSB-first; one out_data_ready pulse at select falling.
- Modes 0, 1 and 2, width 8: a 2-word frame 0x81, 0x7E with in_data_ready held 1 -> both words received in order; MISO bits change only on shift edges.
- DATA_WIDTH=12, MSB_FIRST=0: send 0x5A3 -> in_data = 0x5A3.
- in_data_ready held 0 over 3 words 0x11, 0x22, 0x33 -> in_data = 0x11, overrun = 1. After status_clear, overrun = 0.
- out_data_valid = 0 at select falling -> MISO = 0xFF and underrun = 1. Select raised after 5 bits -> aborted = 1, no valid pulse, and the next frame is received correctly.
- reset asserted mid-word, then a full frame 0xC3 -> all outputs at reset values on the next clock; the subsequent frame yields 0xC3.

Source files
------------

// File: rtl/spi_peripheral_if.sv
// Fabric-side streams of spi_peripheral: a receive stream (peripheral -> fabric)
// and a transmit stream (fabric -> peripheral).
//
// Handshake: a word moves on a clock edge where valid and ready are both 1.
//   Receive:  in_data_valid/in_data driven by the peripheral. Data stays stable
//             while valid is high. in_data_ready comes from the consumer.
//   Transmit: out_data_valid/out_data come from the producer. out_data_ready is
//             a one-cycle pulse from the peripheral, meaning "out_data was taken
//             on the previous edge". The producer then advances to its next word.
interface spi_peripheral_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_data_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_data_ready;
    logic                  out_data_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_data_ready;

    modport master (
        input  in_data_valid, in_data, out_data_ready,
        output in_data_ready, out_data_valid, out_data
    );

    modport slave (
        output in_data_valid, in_data, out_data_ready,
        input  in_data_ready, out_data_valid, out_data
    );
endinterface

// File: rtl/spi_peripheral.sv
// spi_peripheral: oversampled SPI target port. Any word width, any SPI mode.
// Full duplex, with valid/ready streams and sticky status flags.
// Optional feature macro: SPI_PERIPHERAL_TX_EN enables the transmit path
// (MISO shifter, out_data_ready, underrun). Without it the port is receive-only.
module spi_peripheral #(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 1,
    parameter int CPHA        = 1,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             SPI_clock,
    input  logic             SPI_in,
    output logic             SPI_out,
    output logic             SPI_out_enable,
    input  logic             SPI_not_chip_select,
    spi_peripheral_if.slave  bus,
    input  logic             status_clear,
    output logic             overrun,
    output logic             underrun,
    output logic             aborted,
    output logic             busy,
    output logic             debug_state
);
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam int            CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST     = CW'(DATA_WIDTH - 1);
    localparam logic          IDLE_CLK = (CPOL != 0);

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ncs_sync;
    logic sclk_s, mosi_s, ncs_s;
    logic sclk_prev, ncs_prev, mosi_d;
    logic sclk_rise_p, sclk_fall_p, ncs_rise_p, ncs_fall_p;
    logic leading_p, trailing_p, sample_p, shift_p;

    logic start, stop, sample_en, shift_en, word_done, abort_set;

    logic [CW-1:0]         bit_count;
    logic [DATA_WIDTH-1:0] rx_shift, rx_next, in_data_q;
    logic                  in_valid_q;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync[SYNC_STAGES-1];

    // Synchronise the three SPI pins into the system clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync <= {SYNC_STAGES{IDLE_CLK}};
            mosi_sync <= '0;
            ncs_sync  <= '1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_clock};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_in};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], SPI_not_chip_select};
        end
    end

    // Registered edge pulses. mosi_d is delayed by one clock so it lines up with them.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_prev   <= IDLE_CLK;
            ncs_prev    <= 1'b1;
            mosi_d      <= 1'b0;
            sclk_rise_p <= 1'b0;
            sclk_fall_p <= 1'b0;
            ncs_rise_p  <= 1'b0;
            ncs_fall_p  <= 1'b0;
        end else begin
            sclk_prev   <= sclk_s;
            ncs_prev    <= ncs_s;
            mosi_d      <= mosi_s;
            sclk_rise_p <= sclk_s & ~sclk_prev;
            sclk_fall_p <= ~sclk_s & sclk_prev;
            ncs_rise_p  <= ncs_s & ~ncs_prev;
            ncs_fall_p  <= ~ncs_s & ncs_prev;
        end
    end

    assign leading_p  = (CPOL != 0) ? sclk_fall_p : sclk_rise_p;
    assign trailing_p = (CPOL != 0) ? sclk_rise_p : sclk_fall_p;
    assign sample_p   = (CPHA != 0) ? trailing_p : leading_p;
    assign shift_p    = (CPHA != 0) ? leading_p : trailing_p;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-cycle control strobes. A final sample landing in the
    // same cycle as a select rise completes the word and does not abort.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        stop      = 1'b0;
        sample_en = 1'b0;
        shift_en  = 1'b0;
        word_done = 1'b0;
        abort_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall_p) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                sample_en = sample_p;
                shift_en  = shift_p;
                word_done = sample_p && (bit_count == LAST);
                if (ncs_rise_p) begin
                    state_d   = IDLE;
                    stop      = 1'b1;
                    abort_set = !word_done && (sample_p || (bit_count != '0));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Receive word as it will look after the bit being sampled now is shifted in.
    always_comb begin
        if (MSB_FIRST != 0) rx_next = {rx_shift[DATA_WIDTH-2:0], mosi_d};
        else                rx_next = {mosi_d, rx_shift[DATA_WIDTH-1:1]};
    end

    // Receive shifter, bit counter, output word, and sticky overrun/abort flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_count  <= '0;
            rx_shift   <= '0;
            in_data_q  <= '0;
            in_valid_q <= 1'b0;
            overrun    <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            if (sample_en) begin
                rx_shift  <= rx_next;
                bit_count <= word_done ? '0 : bit_count + CW'(1);
            end
            if (start || stop) bit_count <= '0;

            if (word_done) begin
                if (!in_valid_q || bus.in_data_ready) begin
                    in_data_q  <= rx_next;
                    in_valid_q <= 1'b1;
                end
            end else if (in_valid_q && bus.in_data_ready) begin
                in_valid_q <= 1'b0;
            end

            if (word_done && in_valid_q && !bus.in_data_ready) overrun <= 1'b1;
            else if (status_clear)                              overrun <= 1'b0;

            if (abort_set)         aborted <= 1'b1;
            else if (status_clear) aborted <= 1'b0;
        end
    end

    assign bus.in_data_valid = in_valid_q;
    assign bus.in_data       = in_data_q;
    assign busy              = (state_q == ACTIVE);
    assign debug_state       = state_q;

`ifdef SPI_PERIPHERAL_TX_EN
    logic [DATA_WIDTH-1:0] tx_shift, tx_hold, tx_word, tx_shifted;
    logic tx_skip, tx_pend, load_req, ready_q, underrun_q, oe_q;

    assign load_req   = start || word_done;
    assign tx_word    = bus.out_data_valid ? bus.out_data : '1;
    assign tx_shifted = (MSB_FIRST != 0) ? {tx_shift[DATA_WIDTH-2:0], 1'b1}
                                         : {1'b1, tx_shift[DATA_WIDTH-1:1]};

    // Transmit shifter. With CPHA=1 a load presents bit 0 at once, so the next
    // shift edge is skipped. With CPHA=0 a mid-frame reload comes on a sample
    // edge. The new word is parked in tx_hold and moved in on the following
    // shift edge, so MISO only changes on shift edges.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_shift   <= '1;
            tx_hold    <= '1;
            tx_skip    <= 1'b0;
            tx_pend    <= 1'b0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            ready_q <= load_req && bus.out_data_valid;
            oe_q    <= busy;

            if (load_req && !bus.out_data_valid) underrun_q <= 1'b1;
            else if (status_clear)               underrun_q <= 1'b0;

            if (load_req && (start || (CPHA != 0))) begin
                tx_shift <= tx_word;
                tx_skip  <= (CPHA != 0);
                tx_pend  <= 1'b0;
            end else if (load_req) begin
                tx_hold <= tx_word;
                tx_pend <= 1'b1;
            end else if (shift_en) begin
                if (tx_skip) begin
                    tx_skip <= 1'b0;
                end else if (tx_pend) begin
                    tx_shift <= tx_hold;
                    tx_pend  <= 1'b0;
                end else begin
                    tx_shift <= tx_shifted;
                end
            end
        end
    end

    assign SPI_out            = busy ? ((MSB_FIRST != 0) ? tx_shift[DATA_WIDTH-1] : tx_shift[0]) : 1'b1;
    assign SPI_out_enable     = oe_q;
    assign bus.out_data_ready = ready_q;
    assign underrun           = underrun_q;
`else
    logic unused_tx;
    assign unused_tx          = ^{bus.out_data_valid, bus.out_data, shift_en};
    assign SPI_out            = 1'b1;
    assign SPI_out_enable     = 1'b0;
    assign bus.out_data_ready = 1'b0;
    assign underrun           = 1'b0;
`endif
endmodule
